// File: rtl/adder_result_stage_if.sv
// Handshake and status bundle between the adder result stage, the adder upstream,
// the downstream consumer and the status block.
interface adder_result_stage_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_s;
  logic             in_of;
  logic             in_eq;
  logic             in_cary;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_s;
  logic             out_of;
  logic             out_eq;
  logic             out_cary;
  logic             out_zero;
  logic             out_neg;
  logic             sticky_of;
  logic             sticky_clr;
  logic [CNT_W-1:0] of_count;

  // The stage itself.
  modport slave (
    input  in_valid, in_s, in_of, in_eq, in_cary, out_ready, sticky_clr,
    output in_ready, out_valid, out_s, out_of, out_eq, out_cary, out_zero, out_neg,
           sticky_of, of_count
  );

  // The surroundings: upstream adder, downstream consumer and status block.
  modport master (
    output in_valid, in_s, in_of, in_eq, in_cary, out_ready, sticky_clr,
    input  in_ready, out_valid, out_s, out_of, out_eq, out_cary, out_zero, out_neg,
           sticky_of, of_count
  );
endinterface

// File: rtl/adder_result_stage.sv
// Registered result stage behind the 32-bit adder: main register plus one skid entry,
// zero/neg derived at capture, sticky overflow flag and saturating overflow counter.
module adder_result_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input logic                 clk,
  input logic                 rst,
  adder_result_stage_if.slave bus
);

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             of;
    logic             eq;
    logic             cary;
    logic             zero;
    logic             neg;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  entry_t           main_q, main_d, skid_q, skid_d, in_entry;
  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, take;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    in_entry      = '0;
    in_entry.s    = bus.in_s;
    in_entry.of   = bus.in_of;
    in_entry.eq   = bus.in_eq;
    in_entry.cary = bus.in_cary;
    in_entry.zero = (bus.in_s == '0);
    in_entry.neg  = bus.in_s[WIDTH-1];

    accept       = bus.in_valid & in_ready_q;
    take         = main_valid_q & bus.out_ready;
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;

    if (take && skid_valid_q) begin
      // in_ready is low whenever skid is occupied, so no accept can coincide here.
      main_d       = skid_q;
      skid_valid_d = 1'b0;
    end else if (take) begin
      main_valid_d = accept;
      if (accept) main_d = in_entry;
    end else if (accept) begin
      if (!main_valid_q) begin
        main_d       = in_entry;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = in_entry;
        skid_valid_d = 1'b1;
      end
    end

    in_ready_d = !skid_valid_d;

    // Set beats clear when both land on the same edge.
    sticky_d = sticky_q;
    if (accept && bus.in_of)  sticky_d = 1'b1;
    else if (bus.sticky_clr)  sticky_d = 1'b0;

    cnt_d = cnt_q;
    if (accept && bus.in_of && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
      sticky_q     <= 1'b0;
      cnt_q        <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      sticky_q     <= sticky_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = main_valid_q;
  assign bus.out_s     = main_q.s;
  assign bus.out_of    = main_q.of;
  assign bus.out_eq    = main_q.eq;
  assign bus.out_cary  = main_q.cary;
  assign bus.out_zero  = main_q.zero;
  assign bus.out_neg   = main_q.neg;
  assign bus.sticky_of = sticky_q;
  assign bus.of_count  = cnt_q;

endmodule

// File: tb/tb_adder_result_stage.sv
// Self-checking bench for adder_result_stage: table vectors, hand-written corner
// sequences and random traffic against a queue-based reference model.
module tb_adder_result_stage;

  localparam int WIDTH = 32;
  localparam int CNT_W = 8;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adder_result_stage_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) ifc ();

  adder_result_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  typedef struct {
    logic [31:0] s;
    bit          of;
    bit          eq;
    bit          cary;
  } beat_t;

  typedef struct {
    logic [31:0] s;
    bit          of;
    bit          eq;
    bit          cary;
    bit          exp_zero;
    bit          exp_neg;
  } vec_t;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: the stage is a 2-deep FIFO whose head is visible on out_*.
  beat_t mq[$];
  bit    m_sticky    = 1'b0;
  int    m_cnt       = 0;
  bit    m_after_rst = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_ready();
    return !m_after_rst && (mq.size() < 2);
  endfunction

  task automatic compare_all();
    check("out_valid", ifc.out_valid, mq.size() > 0);
    check("in_ready",  ifc.in_ready,  exp_ready());
    check("sticky_of", ifc.sticky_of, m_sticky);
    check("of_count",  ifc.of_count,  m_cnt);
    if (mq.size() > 0) begin
      check("out_s",    ifc.out_s,    mq[0].s);
      check("out_of",   ifc.out_of,   mq[0].of);
      check("out_eq",   ifc.out_eq,   mq[0].eq);
      check("out_cary", ifc.out_cary, mq[0].cary);
      check("out_zero", ifc.out_zero, mq[0].s == 32'd0);
      check("out_neg",  ifc.out_neg,  mq[0].s >= 32'h8000_0000);
    end
  endtask

  task automatic set_in(input bit v, input logic [31:0] s, input bit of, input bit eq,
                        input bit cary);
    ifc.in_valid = v;
    ifc.in_s     = s;
    ifc.in_of    = of;
    ifc.in_eq    = eq;
    ifc.in_cary  = cary;
  endtask

  // One clock edge: predict handshakes from the model, advance it, compare.
  task automatic tick(output bit acc);
    bit    tk;
    beat_t b;
    acc    = ifc.in_valid && exp_ready() && !rst;
    tk     = (mq.size() > 0) && ifc.out_ready && !rst;
    b.s    = ifc.in_s;
    b.of   = ifc.in_of;
    b.eq   = ifc.in_eq;
    b.cary = ifc.in_cary;
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      m_sticky    = 1'b0;
      m_cnt       = 0;
      m_after_rst = 1'b1;
    end else begin
      if (tk) void'(mq.pop_front());
      if (acc) mq.push_back(b);
      if (acc && b.of)        m_sticky = 1'b1;
      else if (ifc.sticky_clr) m_sticky = 1'b0;
      if (acc && b.of && m_cnt < CNT_SAT) m_cnt++;
      m_after_rst = 1'b0;
    end
    compare_all();
  endtask

  vec_t vecs[6];

  initial begin
    bit acc;
    int n_acc;
    bit [31:0] r;

    vecs[0] = '{s: 32'hFFFF_FFFE, of: 0, eq: 0, cary: 1, exp_zero: 0, exp_neg: 1};
    vecs[1] = '{s: 32'h0000_0000, of: 0, eq: 0, cary: 1, exp_zero: 1, exp_neg: 0};
    vecs[2] = '{s: 32'hEE6B_2800, of: 1, eq: 0, cary: 0, exp_zero: 0, exp_neg: 1};
    vecs[3] = '{s: 32'h1194_D800, of: 1, eq: 0, cary: 1, exp_zero: 0, exp_neg: 0};
    vecs[4] = '{s: 32'h0000_0001, of: 0, eq: 1, cary: 0, exp_zero: 0, exp_neg: 0};
    vecs[5] = '{s: 32'h8000_0000, of: 0, eq: 0, cary: 1, exp_zero: 0, exp_neg: 1};

    set_in(0, 0, 0, 0, 0);
    ifc.out_ready  = 1'b1;
    ifc.sticky_clr = 1'b0;

    // Reset, with a beat offered that must be dropped.
    rst = 1'b1;
    set_in(1, 32'h1234, 1, 0, 0);
    tick(acc);
    tick(acc);
    check("rst_out_valid", ifc.out_valid, 0);
    check("rst_in_ready",  ifc.in_ready,  0);
    check("rst_sticky",    ifc.sticky_of, 0);
    check("rst_count",     ifc.of_count,  0);
    check("rst_out_s",     ifc.out_s,     0);
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0);
    tick(acc);
    check("rst_rise_ready", ifc.in_ready, 1);

    // Table vectors, one beat each with out_ready held high.
    for (int i = 0; i < 6; i++) begin
      set_in(1, vecs[i].s, vecs[i].of, vecs[i].eq, vecs[i].cary);
      tick(acc);
      check($sformatf("tbl%0d_valid", i), ifc.out_valid, 1);
      check($sformatf("tbl%0d_s", i),     ifc.out_s,     vecs[i].s);
      check($sformatf("tbl%0d_of", i),    ifc.out_of,    vecs[i].of);
      check($sformatf("tbl%0d_eq", i),    ifc.out_eq,    vecs[i].eq);
      check($sformatf("tbl%0d_cary", i),  ifc.out_cary,  vecs[i].cary);
      check($sformatf("tbl%0d_zero", i),  ifc.out_zero,  vecs[i].exp_zero);
      check($sformatf("tbl%0d_neg", i),   ifc.out_neg,   vecs[i].exp_neg);
      set_in(0, 0, 0, 0, 0);
      tick(acc);
    end
    check("ovf_sticky", ifc.sticky_of, 1);
    check("ovf_count",  ifc.of_count,  2);

    // sticky_clr alone clears the flag but not the counter.
    ifc.sticky_clr = 1'b1;
    tick(acc);
    ifc.sticky_clr = 1'b0;
    check("clr_sticky", ifc.sticky_of, 0);
    check("clr_count",  ifc.of_count,  2);

    // sticky_clr together with an overflow accept: set wins.
    ifc.sticky_clr = 1'b1;
    set_in(1, 32'h7000_0000, 1, 0, 0);
    tick(acc);
    ifc.sticky_clr = 1'b0;
    set_in(0, 0, 0, 0, 0);
    check("clr_set_sticky", ifc.sticky_of, 1);
    check("clr_set_count",  ifc.of_count,  3);
    tick(acc);

    // Backpressure: two beats fill the stage, the third is held off.
    ifc.out_ready = 1'b0;
    set_in(1, 32'h1, 0, 0, 0);
    tick(acc);
    check("bp_ready_after1", ifc.in_ready, 1);
    set_in(1, 32'h2, 0, 0, 0);
    tick(acc);
    check("bp_ready_after2", ifc.in_ready, 0);
    set_in(1, 32'h3, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(acc);
      check("bp_stall_ready", ifc.in_ready, 0);
      check("bp_stall_s",     ifc.out_s,    32'h1);
    end
    ifc.out_ready = 1'b1;
    tick(acc);
    check("bp_rel_s1", ifc.out_s, 32'h2);
    tick(acc);
    check("bp_rel_s2", ifc.out_s, 32'h3);
    set_in(0, 0, 0, 0, 0);
    tick(acc);
    check("bp_drain_valid", ifc.out_valid, 0);

    // Counter saturation from a clean reset.
    rst = 1'b1;
    tick(acc);
    rst = 1'b0;
    tick(acc);
    n_acc = 0;
    for (int i = 0; i < 400 && n_acc < 260; i++) begin
      set_in(1, i, 1, 0, 0);
      tick(acc);
      if (acc) n_acc++;
    end
    check("sat_beats_accepted", n_acc, 260);
    check("sat_count", ifc.of_count, CNT_SAT);
    for (int i = 0; i < 3; i++) tick(acc);
    set_in(0, 0, 0, 0, 0);
    tick(acc);
    check("sat_count_hold", ifc.of_count, CNT_SAT);

    // Reset with both entries occupied.
    ifc.out_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 20 && n_acc < 2; i++) begin
      set_in(1, 32'hA0 + i, 1, 0, 0);
      tick(acc);
      if (acc) n_acc++;
    end
    check("full_before_rst", ifc.in_ready, 0);
    rst = 1'b1;
    tick(acc);
    check("rstfull_valid",  ifc.out_valid, 0);
    check("rstfull_ready",  ifc.in_ready,  0);
    check("rstfull_count",  ifc.of_count,  0);
    check("rstfull_sticky", ifc.sticky_of, 0);
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0);
    tick(acc);
    check("rstfull_ready_rise", ifc.in_ready, 1);

    // Random traffic; upstream holds an offered beat until it is taken.
    for (int i = 0; i < 3000; i++) begin
      if (!ifc.in_valid) begin
        r = $urandom;
        set_in($urandom_range(0, 2) != 0, ($urandom_range(0, 7) == 0) ? 32'd0 : r,
               $urandom_range(0, 3) == 0, $urandom_range(0, 1), $urandom_range(0, 1));
      end
      ifc.out_ready  = $urandom_range(0, 2) != 0;
      ifc.sticky_clr = $urandom_range(0, 9) == 0;
      rst            = $urandom_range(0, 199) == 0;
      tick(acc);
      if (acc || rst) ifc.in_valid = 1'b0;
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
